// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Write-side master for the 32x32 register file. Results are buffered in a
//   small FIFO and drained at most one per cycle onto the registered we3/A3/WD3
//   write port. Read-after-write hazards against pending writes (queue entries
//   and the output stage) are flagged combinationally.
//
//   Optional build macro:
//     WB_FORWARD_EN  adds fwd_d1/fwd_d2, carrying the newest pending value for
//                    the hazard addresses (0 when there is no hazard).
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_en,
    output logic                     we3,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [ADDR_W-1:0]        hz_a1,
    input  logic [ADDR_W-1:0]        hz_a2,
    output logic                     hz1,
    output logic                     hz2
`ifdef WB_FORWARD_EN
    ,
    output logic [DATA_W-1:0]        fwd_d1,
    output logic [DATA_W-1:0]        fwd_d2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              push;
    logic              pop;
    logic              hz1_raw;
    logic              hz2_raw;
    logic [PTR_W-1:0]  idx;
`ifdef WB_FORWARD_EN
    logic [DATA_W-1:0] fwd1_raw;
    logic [DATA_W-1:0] fwd2_raw;
`endif

    // Handshake: acceptance depends only on occupancy, so a full queue never
    // takes a new entry in the same cycle it pops one.
    always_comb begin
        in_ready = (count < CNT_W'(DEPTH)) & ~reset;
        push     = in_valid & in_ready;
        pop      = drain_en & (count != '0);
    end

    // Entry storage; only written on an accepted transfer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= in_addr;
            mem_data[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            we3    <= 1'b0;
            A3     <= '0;
            WD3    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                // $zero entries drain normally but never enable the write.
                we3    <= (mem_addr[rd_ptr] != '0);
                A3     <= mem_addr[rd_ptr];
                WD3    <= mem_data[rd_ptr];
            end else begin
                we3    <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Hazard search: output stage first, then queue entries oldest to
    // youngest so the last match seen is the newest pending value.
    always_comb begin
        hz1_raw = 1'b0;
        hz2_raw = 1'b0;
        idx     = '0;
`ifdef WB_FORWARD_EN
        fwd1_raw = '0;
        fwd2_raw = '0;
`endif
        if (we3 && (A3 == hz_a1)) begin
            hz1_raw = 1'b1;
`ifdef WB_FORWARD_EN
            fwd1_raw = WD3;
`endif
        end
        if (we3 && (A3 == hz_a2)) begin
            hz2_raw = 1'b1;
`ifdef WB_FORWARD_EN
            fwd2_raw = WD3;
`endif
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if (mem_addr[idx] == hz_a1) begin
                    hz1_raw = 1'b1;
`ifdef WB_FORWARD_EN
                    fwd1_raw = mem_data[idx];
`endif
                end
                if (mem_addr[idx] == hz_a2) begin
                    hz2_raw = 1'b1;
`ifdef WB_FORWARD_EN
                    fwd2_raw = mem_data[idx];
`endif
                end
            end
        end
    end

    // $zero is never a hazard: reads of register 0 always return 0.
    always_comb begin
        hz1 = hz1_raw & (hz_a1 != '0);
        hz2 = hz2_raw & (hz_a2 != '0);
`ifdef WB_FORWARD_EN
        fwd_d1 = hz1 ? fwd1_raw : '0;
        fwd_d2 = hz2 ? fwd2_raw : '0;
`endif
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed testbench for reg_writeback_queue (DEPTH=4, DATA_W=32, ADDR_W=5).
module tb_reg_writeback_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_en;
    logic        we3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [2:0]  count;
    logic [4:0]  hz_a1;
    logic [4:0]  hz_a2;
    logic        hz1;
    logic        hz2;
`ifdef WB_FORWARD_EN
    logic [31:0] fwd_d1;
    logic [31:0] fwd_d2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .drain_en (drain_en),
        .we3      (we3),
        .A3       (A3),
        .WD3      (WD3),
        .count    (count),
        .hz_a1    (hz_a1),
        .hz_a2    (hz_a2),
        .hz1      (hz1),
        .hz2      (hz2)
`ifdef WB_FORWARD_EN
        ,
        .fwd_d1   (fwd_d1),
        .fwd_d2   (fwd_d2)
`endif
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        drain_en = 1'b0; hz_a1 = '0; hz_a2 = '0;
        tick(); tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (we3 !== 1'b0) begin bad++; $display("FAIL rst_we3 got=%b exp=0", we3); end
        total++; if ({A3, WD3} !== 37'd0) begin bad++; $display("FAIL rst_a3_wd3 got=%0d/%h exp=0/0", A3, WD3); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_latency();
        in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEAD_BEEF; drain_en = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (count !== 3'd1 || we3 !== 1'b0) begin bad++; $display("FAIL lat_accept got count=%0d we3=%b exp 1/0", count, we3); end
        tick();
        total++; if (we3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL lat_write got we3=%b A3=%0d WD3=%h exp 1/5/deadbeef", we3, A3, WD3); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL lat_count got=%0d exp=0", count); end
        tick();
        total++; if (we3 !== 1'b0 || A3 !== 5'd5) begin bad++; $display("FAIL lat_hold got we3=%b A3=%0d exp 0/5", we3, A3); end
    endtask

    task automatic test_full_order();
        logic [4:0]  exp_a [5];
        logic [31:0] exp_d [5];
        exp_a[0] = 5'd1; exp_a[1] = 5'd2; exp_a[2] = 5'd3; exp_a[3] = 5'd4; exp_a[4] = 5'd9;
        exp_d[0] = 32'h100; exp_d[1] = 32'h101; exp_d[2] = 32'h102; exp_d[3] = 32'h103; exp_d[4] = 32'h999;
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = exp_a[i]; in_data = exp_d[i];
            tick();
        end
        total++; if (count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full_state got count=%0d rdy=%b exp 4/0", count, in_ready); end
        in_addr = 5'd9; in_data = 32'h999;
        tick(); tick();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_held got count=%0d exp=4", count); end
        drain_en = 1'b1;
        tick();
        total++; if (count !== 3'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL full_first_pop got count=%0d rdy=%b exp 3/1", count, in_ready); end
        total++; if (we3 !== 1'b1 || A3 !== exp_a[0] || WD3 !== exp_d[0]) begin
            bad++; $display("FAIL order_0 got we3=%b A3=%0d WD3=%h exp 1/%0d/%h", we3, A3, WD3, exp_a[0], exp_d[0]); end
        tick();
        in_valid = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_push_pop got count=%0d exp=3", count); end
        for (int i = 1; i < 5; i++) begin
            if (i > 1) tick();
            total++; if (we3 !== 1'b1 || A3 !== exp_a[i] || WD3 !== exp_d[i]) begin
                bad++; $display("FAIL order_%0d got we3=%b A3=%0d WD3=%h exp 1/%0d/%h", i, we3, A3, WD3, exp_a[i], exp_d[i]); end
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL order_empty got count=%0d exp=0", count); end
        tick();
        total++; if (we3 !== 1'b0) begin bad++; $display("FAIL order_idle got we3=%b exp=0", we3); end
    endtask

    task automatic test_zero_reg();
        logic seen;
        seen = 1'b0;
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'h1234; drain_en = 1'b1;
        tick();
        in_valid = 1'b0;
        if (we3 === 1'b1) seen = 1'b1;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL zero_accept got count=%0d exp=1", count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (we3 === 1'b1) seen = 1'b1;
            if (i == 0) begin
                total++; if (A3 !== 5'd0 || WD3 !== 32'h1234) begin bad++; $display("FAIL zero_out got A3=%0d WD3=%h exp 0/1234", A3, WD3); end
            end
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", count); end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL zero_we3 got seen=%b exp=0", seen); end
    endtask

    task automatic test_hazard();
        drain_en = 1'b0;
        in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        hz_a1 = 5'd7; hz_a2 = 5'd3;
        #1;
        total++; if (hz1 !== 1'b1 || hz2 !== 1'b0) begin bad++; $display("FAIL hz_queue got hz1=%b hz2=%b exp 1/0", hz1, hz2); end
`ifdef WB_FORWARD_EN
        total++; if (fwd_d1 !== 32'hB || fwd_d2 !== 32'h0) begin bad++; $display("FAIL fwd_newest got d1=%h d2=%h exp b/0", fwd_d1, fwd_d2); end
`endif
        hz_a1 = 5'd0; hz_a2 = 5'd7;
        #1;
        total++; if (hz1 !== 1'b0 || hz2 !== 1'b1) begin bad++; $display("FAIL hz_zero got hz1=%b hz2=%b exp 0/1", hz1, hz2); end
        hz_a1 = 5'd7; hz_a2 = 5'd0;
        drain_en = 1'b1;
        tick(); tick();
        drain_en = 1'b0;
        #1;
        total++; if (count !== 3'd0 || we3 !== 1'b1 || hz1 !== 1'b1) begin
            bad++; $display("FAIL hz_outstage got count=%0d we3=%b hz1=%b exp 0/1/1", count, we3, hz1); end
`ifdef WB_FORWARD_EN
        total++; if (fwd_d1 !== 32'hB) begin bad++; $display("FAIL fwd_outstage got=%h exp=b", fwd_d1); end
`endif
        tick();
        total++; if (hz1 !== 1'b0) begin bad++; $display("FAIL hz_cleared got=%b exp=0", hz1); end
        hz_a1 = 5'd0;
    endtask

    task automatic test_back_to_back();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = 5'(10 + i); in_data = 32'(32'h200 + i);
            tick();
        end
        in_addr = 5'd20; in_data = 32'h777;
        drain_en = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (count !== 3'd3 || A3 !== 5'd10 || we3 !== 1'b1) begin
            bad++; $display("FAIL b2b_pop_only got count=%0d A3=%0d we3=%b exp 3/10/1", count, A3, we3); end
        tick(); tick(); tick();
        total++; if (count !== 3'd0 || A3 !== 5'd13 || WD3 !== 32'h203) begin
            bad++; $display("FAIL b2b_last got count=%0d A3=%0d WD3=%h exp 0/13/203", count, A3, WD3); end
        tick();
        total++; if (we3 !== 1'b0 || A3 !== 5'd13) begin bad++; $display("FAIL b2b_no_extra got we3=%b A3=%0d exp 0/13", we3, A3); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = 5'(1 + i); in_data = 32'(32'h300 + i);
            tick();
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        tick();
        total++; if (we3 !== 1'b1 || count !== 3'd2) begin bad++; $display("FAIL rm_inflight got we3=%b count=%0d exp 1/2", we3, count); end
        reset = 1'b1;
        tick();
        total++; if (count !== 3'd0 || we3 !== 1'b0) begin bad++; $display("FAIL rm_cleared got count=%0d we3=%b exp 0/0", count, we3); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (we3 === 1'b1 || count !== 3'd0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_no_writes got activity=%b exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full_order();
        test_zero_reg();
        test_hazard();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
